// File: rtl/fifo_rd_packer.sv
// Read-side drain for the dual-clock FIFO: packs PACK FWFT words into one wide valid/ready word.
// Define FIFO_RD_PACK_TIMEOUT_EN to flush a partial pack after TIMEOUT idle cycles.
module fifo_rd_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK       = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                         rclk,
    input  logic                         rrst,
    input  logic                         fifo_rempty,
    input  logic [DATA_WIDTH-1:0]        fifo_rdata,
    output logic                         fifo_ren,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [DATA_WIDTH*PACK-1:0]   m_data,
    output logic [PACK-1:0]              m_keep
);

    localparam int CW = $clog2(PACK);

    typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

    state_t                       state_reg;
    state_t                       state_next;
    logic [CW-1:0]                cnt_reg;
    logic [DATA_WIDTH-1:0]        pack_reg [PACK];
    logic                         m_valid_reg;
    logic [DATA_WIDTH*PACK-1:0]   m_data_reg;
    logic [PACK-1:0]              m_keep_reg;

    logic                         pop;
    logic                         last_pop;
    logic                         slot_free;
    logic                         hold_release;
    logic                         flush;
    logic [DATA_WIDTH*PACK-1:0]   full_word;
    logic [DATA_WIDTH*PACK-1:0]   hold_word;
    logic [DATA_WIDTH*PACK-1:0]   part_word;
    logic [PACK-1:0]              part_keep;

    if (PACK < 2 || PACK > 16 || TIMEOUT < 2) begin : g_bad_param
        $error("fifo_rd_packer: PACK must be 2..16 and TIMEOUT at least 2");
    end

    assign pop          = fifo_ren;
    assign last_pop     = pop && (cnt_reg == CW'(PACK - 1));
    assign slot_free    = !m_valid_reg || m_ready;
    assign hold_release = (state_reg == HOLD) && m_valid_reg && m_ready;

    // full_word bypasses the word being popped into the top lane this cycle
    for (genvar gi = 0; gi < PACK; gi++) begin : g_lane
        if (gi == PACK - 1) begin : g_top
            assign full_word[gi*DATA_WIDTH +: DATA_WIDTH] = fifo_rdata;
        end else begin : g_low
            assign full_word[gi*DATA_WIDTH +: DATA_WIDTH] = pack_reg[gi];
        end
        assign hold_word[gi*DATA_WIDTH +: DATA_WIDTH] = pack_reg[gi];
        assign part_keep[gi] = (cnt_reg > CW'(gi));
        assign part_word[gi*DATA_WIDTH +: DATA_WIDTH] =
            part_keep[gi] ? pack_reg[gi] : {DATA_WIDTH{1'b0}};
    end

`ifdef FIFO_RD_PACK_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT + 1);

    logic [IW-1:0] idle_reg;

    // The current idle cycle counts, so the flush edge ends the TIMEOUT-th idle cycle.
    assign flush = (state_reg == FILL) && !pop && slot_free &&
                   (idle_reg >= IW'(TIMEOUT - 1));

    always_ff @(posedge rclk) begin
        if (rrst || pop || state_reg != FILL) begin
            idle_reg <= '0;
        end else if (idle_reg != IW'(TIMEOUT)) begin
            idle_reg <= idle_reg + 1'b1;
        end
    end
`else
    assign flush = 1'b0;
`endif

    always_ff @(posedge rclk) begin
        if (rrst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (pop) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                if (last_pop) begin
                    state_next = slot_free ? IDLE : HOLD;
                end else if (flush) begin
                    state_next = IDLE;
                end
            end
            HOLD: begin
                if (hold_release) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Pop strobe never looks at m_ready, only at state and the empty flag.
    always_comb begin
        fifo_ren = !rrst && !fifo_rempty && (state_reg != HOLD);
    end

    always_ff @(posedge rclk) begin
        if (pop) begin
            pack_reg[cnt_reg] <= fifo_rdata;
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            cnt_reg     <= '0;
            m_valid_reg <= 1'b0;
            m_data_reg  <= '0;
            m_keep_reg  <= '0;
        end else begin
            if (pop) begin
                cnt_reg <= last_pop ? '0 : cnt_reg + 1'b1;
            end else if (flush) begin
                cnt_reg <= '0;
            end

            if (last_pop && slot_free) begin
                m_valid_reg <= 1'b1;
                m_data_reg  <= full_word;
                m_keep_reg  <= '1;
            end else if (hold_release) begin
                m_valid_reg <= 1'b1;
                m_data_reg  <= hold_word;
                m_keep_reg  <= '1;
            end else if (flush) begin
                m_valid_reg <= 1'b1;
                m_data_reg  <= part_word;
                m_keep_reg  <= part_keep;
            end else if (m_valid_reg && m_ready) begin
                m_valid_reg <= 1'b0;
            end
        end
    end

    assign m_valid = m_valid_reg;
    assign m_data  = m_data_reg;
    assign m_keep  = m_keep_reg;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Scoreboard bench for fifo_rd_packer: a FWFT FIFO model feeds the DUT, packed words are
// predicted from the popped stimulus and compared on every accepted output word.
module tb_fifo_rd_packer;

    localparam int DW = 8;
    localparam int PK = 4;
    localparam int TO = 8;

    logic          rclk = 1'b0;
    logic          rrst = 1'b1;
    logic          fifo_rempty = 1'b1;
    logic [DW-1:0] fifo_rdata = '0;
    logic          fifo_ren;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [31:0]   m_data;
    logic [3:0]    m_keep;

    fifo_rd_packer #(.DATA_WIDTH(DW), .PACK(PK), .TIMEOUT(TO)) dut (
        .rclk        (rclk),
        .rrst        (rrst),
        .fifo_rempty (fifo_rempty),
        .fifo_rdata  (fifo_rdata),
        .fifo_ren    (fifo_ren),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_keep      (m_keep)
    );

    always #5 rclk = ~rclk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  fifo_q[$];
    bit          hold_empty = 1'b0;
    logic [31:0] exp_d[$];
    logic [3:0]  exp_k[$];
    logic [31:0] acc_d = '0;
    int          acc_n = 0;
    logic        s_ren, s_valid;
    logic [31:0] s_data;
    logic [3:0]  s_keep;
    logic [31:0] last_out = '0;
    int          n_out = 0;
    int          n_pop = 0;
    int          cyc   = 0;
    int          first_v, last_p, n_v, prev_v, p0, o0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, expv);
        end
    endtask

    task automatic reset_model();
        acc_n = 0;
        acc_d = '0;
        exp_d.delete();
        exp_k.delete();
    endtask

    // One clock: drive FIFO head, snapshot outputs before the edge, score, then advance.
    task automatic cycle();
        fifo_rempty = hold_empty || (fifo_q.size() == 0);
        fifo_rdata  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
        #1;
        s_ren   = fifo_ren;
        s_valid = m_valid;
        s_data  = m_data;
        s_keep  = m_keep;
        if (m_valid && m_ready) begin
            $display("cycle %0d: out data=%h keep=%h", cyc, m_data, m_keep);
            n_out++;
            last_out = m_data;
            if (exp_d.size() == 0) begin
                check("spurious_word", {31'h0, m_valid}, 32'h0);
            end else begin
                check("word_data", m_data, exp_d.pop_front());
                check("word_keep", {28'h0, m_keep}, {28'h0, exp_k.pop_front()});
            end
        end
        if (fifo_ren) begin
            acc_d[acc_n*8 +: 8] = fifo_q[0];
            acc_n++;
            n_pop++;
            if (acc_n == PK) begin
                exp_d.push_back(acc_d);
                exp_k.push_back(4'hF);
                acc_n = 0;
                acc_d = '0;
            end
        end
        @(posedge rclk);
        #1;
        if (s_ren) void'(fifo_q.pop_front());
        cyc++;
    endtask

    initial begin
        @(posedge rclk);
        #1;

        // Reset with a non-empty FIFO
        fifo_q = {8'h11, 8'h22, 8'h33, 8'h44};
        m_ready = 1'b1;
        rrst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("rst_ren", {31'h0, s_ren}, 32'h0);
            check("rst_valid", {31'h0, s_valid}, 32'h0);
            check("rst_keep", {28'h0, s_keep}, 32'h0);
        end
        rrst = 1'b0;
        reset_model();

        // Basic pack
        first_v = -1; last_p = -1; n_v = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (s_ren) last_p = i;
            if (s_valid) begin
                n_v++;
                if (first_v < 0) first_v = i;
                check("basic_data", s_data, 32'h44332211);
                check("basic_keep", {28'h0, s_keep}, 32'hF);
            end
        end
        check("basic_valid_cycles", n_v, 1);
        check("basic_latency", first_v - last_p, 1);

        // Backpressure: 12 words, m_ready low
        m_ready = 1'b0;
        for (int i = 1; i <= 12; i++) fifo_q.push_back(8'(i));
        p0 = n_pop;
        for (int i = 0; i < 16; i++) cycle();
        check("bp_pops", n_pop - p0, 8);
        check("bp_ren_low", {31'h0, s_ren}, 32'h0);
        o0 = n_out;
        m_ready = 1'b1;
        for (int i = 0; i < 40 && (fifo_q.size() != 0 || exp_d.size() != 0); i++) cycle();
        check("bp_words", n_out - o0, 3);
        check("bp_drained", exp_d.size(), 0);

        // Final pop coinciding with an accept: no bubble, no HOLD
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) fifo_q.push_back(8'h40 + 8'(i));
        p0 = n_pop;
        for (int i = 0; i < 7; i++) cycle();
        m_ready = 1'b1;
        cycle();
        check("coinc_pop", {31'h0, s_ren}, 32'h1);
        cycle();
        check("coinc_valid", {31'h0, s_valid}, 32'h1);
        check("coinc_pops", n_pop - p0, 8);
        cycle();

        // Back-to-back stream
        for (int i = 0; i < 16; i++) fifo_q.push_back(8'h20 + 8'(i));
        p0 = n_pop; prev_v = -1; n_v = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (i == 15) check("b2b_pops", n_pop - p0, 16);
            if (s_valid) begin
                if (prev_v >= 0) check("b2b_spacing", i - prev_v, 4);
                prev_v = i;
                n_v++;
            end
        end
        check("b2b_words", n_v, 4);

        // Reset after 2 of 4 pops
        fifo_q.push_back(8'hB0);
        fifo_q.push_back(8'hB1);
        cycle();
        cycle();
        rrst = 1'b1;
        cycle();
        rrst = 1'b0;
        reset_model();
        o0 = n_out;
        fifo_q = {8'hA0, 8'hA1, 8'hA2, 8'hA3};
        for (int i = 0; i < 8; i++) cycle();
        check("midrst_words", n_out - o0, 1);
        check("midrst_word", last_out, 32'hA3A2A1A0);

        // Idle timeout with a 2-word partial pack
        fifo_q = {8'h55, 8'h66};
        first_v = -1; last_p = -1; n_v = 0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            if (s_ren) last_p = i;
        end
        check("to_pops", last_p, 1);
`ifdef FIFO_RD_PACK_TIMEOUT_EN
        exp_d.push_back(32'h00006655);
        exp_k.push_back(4'h3);
        acc_n = 0;
        acc_d = '0;
`endif
        for (int i = 2; i < 30; i++) begin
            cycle();
            if (s_valid) begin
                n_v++;
                if (first_v < 0) first_v = i;
            end
        end
`ifdef FIFO_RD_PACK_TIMEOUT_EN
        check("to_words", n_v, 1);
        check("to_delay", first_v - last_p, TO + 1);
        check("to_word", last_out, 32'h00006655);
`else
        check("to_no_valid", n_v, 0);
`endif
        check("sb_empty", exp_d.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_rd_packer.md
# fifo_rd_packer

Read-side drain for the dual-clock FIFO. The block sits entirely in the read clock domain and pops words from the FIFO read port, which is first-word-fall-through: `rdata` is valid whenever `rempty` is low, and a pop takes effect on the `rclk` edge where `ren` is high. It packs `PACK` consecutive FIFO words into one wide word and presents the result on a valid/ready output stream with per-lane keep bits. An optional idle timeout flushes a partially filled word.

## Interface
- `DATA_WIDTH`, 8, FIFO word width.
- `PACK`, 4, FIFO words per output word; legal range 2..16.
- `TIMEOUT`, 64, idle cycles before a partial flush; legal range ≥2; used only when the timeout macro is defined.

- `rclk` in 1: the single clock, the FIFO read clock.
- `rrst` in 1: reset, **synchronous, active-high**.
- `fifo_rempty` in 1: FIFO empty flag.
- `fifo_rdata` in `DATA_WIDTH`: FIFO head word, valid while `fifo_rempty` is 0.
- `fifo_ren` out 1: pop strobe, combinational.
- `m_valid` out 1: output word valid.
- `m_ready` in 1: downstream accept.
- `m_data` out `DATA_WIDTH*PACK`: packed word; lane k is `m_data[k*DATA_WIDTH +: DATA_WIDTH]`.
- `m_keep` out `PACK`: lane k holds data.

## Operation
- **Storage**
  - A pack register holds `PACK` lanes, with a lane counter `cnt` of width `$clog2(PACK)`.
  - An output register drives `m_data`, `m_keep` and `m_valid`.
- **Pop condition**
  - `fifo_ren = !rrst && !fifo_rempty && state != HOLD`.
  - A pop writes `fifo_rdata` into lane `cnt` at that edge.
  - The first word popped lands in lane 0 (little-endian lane order).
- **States**
  - IDLE: `cnt` = 0, nothing held.
  - FILL: 0 < `cnt` < `PACK`.
  - HOLD: pack register complete, output register occupied.
- **Transitions**
  - IDLE→FILL on a pop.
  - When the pop fills lane `PACK-1` (the final pop):
    - If the output slot is free or draining this cycle (`!m_valid || m_ready`), load the output register with `m_keep` all ones, clear `cnt`, and go to IDLE.
    - Otherwise go to HOLD.
  - HOLD: on `m_valid && m_ready`, load the output register from the pack register at that same edge and go to IDLE. No pops occur in HOLD.
- **Output handshake**
  - `m_valid` stays high until `m_valid && m_ready`.
  - `m_data` and `m_keep` are stable while `m_valid && !m_ready`.
  - A transfer with no new load clears `m_valid` at the next edge.
- **Simultaneous events**
  - The final pop and a downstream accept in the same cycle produce back-to-back output words with no bubble.
  - `fifo_rempty` rising in the same cycle as `m_ready` has no interaction.
- **Unfilled lanes** are driven as zero in the output register.
- **Reset mid-operation**
  - Any partial pack and any unaccepted output word are discarded.
  - The FIFO contents are untouched; the FIFO's own resets govern them.

## Timing
- **Reset values:** `m_valid`=0, `m_data`=0, `m_keep`=0, `fifo_ren`=0 while `rrst`=1, state IDLE, `cnt`=0.
- **Latency:** the edge that pops lane `PACK-1` raises `m_valid` right after that edge (1 cycle), provided the output slot is free.
- **Throughput:** one FIFO pop per cycle with `m_ready` held high, i.e. one output word every `PACK` cycles.
- **Downstream stall:**
  - The pipeline absorbs one complete output word plus one complete pack; then `fifo_ren` drops.
  - Pops resume in the cycle after the HOLD→IDLE transition.
- **`fifo_ren` path:** combinational from `fifo_rempty` and state only; it never depends on `m_ready` in the same cycle.

## Configuration
- **Macro:** `FIFO_RD_PACK_TIMEOUT_EN`.
- **Defined:**
  - An idle counter of width `$clog2(TIMEOUT+1)` clears on every pop and on entry to FILL, and increments each FILL cycle without a pop, saturating at `TIMEOUT`.
  - When it reaches `TIMEOUT` and the output slot is free or draining, the partial pack loads into the output register and the state goes to IDLE.
  - The loaded word has `m_keep` = `cnt` low-order ones and zeros in the unfilled lanes.
  - If the output slot is not free, the flush waits with the counter saturated.
  - A pop arriving in the same cycle as the flush wins: it lands in the lane and the counter restarts.
- **Not defined:**
  - There is no counter.
  - A partial pack is held indefinitely.
  - `m_keep` is always all ones when `m_valid` is high.

## Test plan
- **Reset:** assert `rrst` for 3 cycles with `fifo_rempty`=0 → `fifo_ren`=0, `m_valid`=0, `m_keep`=0 throughout.
- **Basic pack:** FIFO supplies 0x11,0x22,0x33,0x44 on consecutive cycles, `m_ready`=1 → `m_valid` for exactly 1 cycle with `m_data`=0x44332211, `m_keep`=4'hF, one cycle after the fourth pop.
- **Backpressure:** 12 words streamed with `m_ready`=0 → exactly 8 pops, then `fifo_ren`=0. Raise `m_ready` → words 0x..04030201, 0x..08070605, 0x..0C0B0A09 appear in order, with no loss or duplication.
- **Back-to-back:** continuous stream with `m_ready`=1 → `m_valid` high every 4th cycle; there is no bubble when the final pop coincides with an accept.
- **Mid-reset:** reset pulse after 2 of 4 pops, then 4 fresh words 0xA0..0xA3 → the output is 0xA3A2A1A0; no stale lanes.
- **Timeout (macro defined, `TIMEOUT`=8):** pop 0x55,0x66, then `fifo_rempty`=1 → exactly 8 idle cycles later, `m_data`=0x00006655 and `m_keep`=4'h3. Without the macro, `m_valid` stays 0 indefinitely.
